csa_result_reader: RTL

// Read-side companion to the CSA calculation RAM. Captures each 48-bit (6-byte) result word when it is strobed
// out of the stream-cypher engine and packs the results little-endian into a byte buffer.

---
 rtl/csa_result_reader_if.sv | 28 ++
 rtl/csa_result_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/csa_result_reader_if.sv
// csa_result_reader_if
// Bundles the two streams that cross the result reader boundary:
//   - result stream from the CSA engine: result_in (48 bits), result_valid strobe
//   - register read port from the AXI-lite slave: ren, raddr -> rdata, rvalid
// Modports:
//   master : the side producing results and issuing register reads
//   slave  : the result reader itself (consumes results, answers reads)
interface csa_result_reader_if #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_W    = 32
) ();
    logic [47:0]          result_in;
    logic                 result_valid;
    logic                 ren;
    logic [ADDR_BITS-1:0] raddr;
    logic [DATA_W-1:0]    rdata;
    logic                 rvalid;

    modport master (
        output result_in, result_valid, ren, raddr,
        input  rdata, rvalid
    );

    modport slave (
        input  result_in, result_valid, ren, raddr,
        output rdata, rvalid
    );
endinterface

// File: rtl/csa_result_reader.sv
// csa_result_reader
// Captures 48-bit CSA results into a buffer, presents them as a little-endian
// packed byte stream and serves that stream as 32-bit words through a register
// read port, together with progress and overflow/underflow status.
// Ports:
//   S_AXI_ACLK     clock, rising edge
//   S_AXI_ARESETN  asynchronous active-low reset
//   arm            pulse: clear counters/flags, resample item_total, start a run
//   item_total     results expected for the run (clamped to MAX_ITEMS)
//   bus            result stream in + register read port (slave modport)
//   done           all results captured and not yet fully drained
//   overflow       sticky: result strobed outside collection
//   underflow      sticky: DATA read with no complete word available
// Register map: 0 STATUS, 1 DATA, 2 AVAIL, 3 TOTAL, others read 0.
module csa_result_reader #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int OPT_MEM_ADDR_BITS  = 3,
    parameter int MAX_ITEMS          = 16
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    input  logic               arm,
    input  logic [15:0]        item_total,
    csa_result_reader_if.slave bus,
    output logic               done,
    output logic               overflow,
    output logic               underflow
);
    localparam int AW        = OPT_MEM_ADDR_BITS + 1;
    localparam int WORDS_MAX = (3 * MAX_ITEMS + 1) / 2;
    localparam int IW        = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;

    localparam logic [AW-1:0] REG_STATUS = AW'(0);
    localparam logic [AW-1:0] REG_DATA   = AW'(1);
    localparam logic [AW-1:0] REG_AVAIL  = AW'(2);
    localparam logic [AW-1:0] REG_TOTAL  = AW'(3);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t                        state_reg, state_next;
    logic [15:0]                   total_reg, total_next;
    logic [15:0]                   item_count_reg, item_count_next;
    logic [15:0]                   rd_word_reg, rd_word_next;
    logic                          overflow_reg, overflow_next;
    logic                          underflow_reg, underflow_next;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                          rvalid_reg, rvalid_next;
    logic                          wr_en;

    // One entry per result; the packed byte stream is simply the entries laid
    // end to end, so word w is bits [32w +: 32] of the flattened buffer.
    logic [47:0]              mem [MAX_ITEMS];
    logic [32*WORDS_MAX-1:0]  flat;
    logic [31:0]              word_arr [WORDS_MAX];
    logic [31:0]              word_sel;
    logic [31:0]              word_masked;
    logic [17:0]              bytes_valid;
    logic [15:0]              words_total;
    logic [15:0]              words_avail;
    logic [15:0]              clamped_total;
    logic [31:0]              status_word;

    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_en) begin
            mem[item_count_reg[IW-1:0]] <= bus.result_in;
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_ITEMS; gi++) begin : g_flat
            assign flat[48*gi +: 48] = mem[gi];
        end
        if ((MAX_ITEMS % 2) != 0) begin : g_pad
            assign flat[32*WORDS_MAX-1 -: 16] = '0;
        end
        for (genvar gi = 0; gi < WORDS_MAX; gi++) begin : g_words
            assign word_arr[gi] = flat[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < WORDS_MAX; i++) begin
            if (rd_word_reg == 16'(i)) begin
                word_sel = word_arr[i];
            end
        end
    end

    // Lanes beyond the captured bytes read as zero; this hides stale buffer
    // contents and zero-pads the last word of an odd-length run.
    assign bytes_valid = {2'b00, item_count_reg} * 18'd6;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_masked[8*gi +: 8] =
                (({rd_word_reg, 2'b00} + 18'(gi)) < bytes_valid) ? word_sel[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign words_total   = 16'((({2'b00, total_reg} * 18'd3) + 18'd1) >> 1);
    // Outside COLLECT every result of the run is present, so the whole run is readable.
    assign words_avail   = (state_reg == S_COLLECT)
                         ? 16'(({2'b00, item_count_reg} * 18'd3) >> 1)
                         : words_total;
    assign clamped_total = (item_total > 16'(MAX_ITEMS)) ? 16'(MAX_ITEMS) : item_total;
    assign status_word   = {overflow_reg, underflow_reg, (state_reg == S_DONE),
                            (state_reg == S_COLLECT), 12'b0, item_count_reg};

    always_comb begin
        state_next      = state_reg;
        total_next      = total_reg;
        item_count_next = item_count_reg;
        rd_word_next    = rd_word_reg;
        overflow_next   = overflow_reg;
        underflow_next  = underflow_reg;
        rdata_next      = '0;
        rvalid_next     = bus.ren;
        wr_en           = 1'b0;

        if (arm) begin
            // Restart dominates: any concurrent result or read is ignored.
            total_next      = clamped_total;
            item_count_next = '0;
            rd_word_next    = '0;
            overflow_next   = 1'b0;
            underflow_next  = 1'b0;
            state_next      = (clamped_total != 16'd0) ? S_COLLECT : S_IDLE;
        end else begin
            if (bus.result_valid) begin
                if (state_reg == S_COLLECT) begin
                    wr_en           = 1'b1;
                    item_count_next = item_count_reg + 16'd1;
                    if (item_count_reg + 16'd1 == total_reg) begin
                        state_next = S_DONE;
                    end
                end else begin
                    overflow_next = 1'b1;
                end
            end

            // Reads see pre-write availability, so a same-cycle result never
            // makes its own bytes readable early.
            if (bus.ren) begin
                case (bus.raddr)
                    REG_STATUS: rdata_next = status_word;
                    REG_DATA: begin
                        if (rd_word_reg < words_avail) begin
                            rdata_next   = word_masked;
                            rd_word_next = rd_word_reg + 16'd1;
                            if ((state_reg == S_DONE) && (rd_word_reg == words_total - 16'd1)) begin
                                state_next = S_IDLE;
                            end
                        end else begin
                            underflow_next = 1'b1;
                        end
                    end
                    REG_AVAIL:  rdata_next = {16'b0, words_avail - rd_word_reg};
                    REG_TOTAL:  rdata_next = {16'b0, total_reg};
                    default:    rdata_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_reg      <= S_IDLE;
            total_reg      <= '0;
            item_count_reg <= '0;
            rd_word_reg    <= '0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            rdata_reg      <= '0;
            rvalid_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            total_reg      <= total_next;
            item_count_reg <= item_count_next;
            rd_word_reg    <= rd_word_next;
            overflow_reg   <= overflow_next;
            underflow_reg  <= underflow_next;
            rdata_reg      <= rdata_next;
            rvalid_reg     <= rvalid_next;
        end
    end

    assign bus.rdata  = rdata_reg;
    assign bus.rvalid = rvalid_reg;
    assign done       = (state_reg == S_DONE);
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;
endmodule
